// File: rtl/wbuf_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : wbuf_tile_scheduler
// Brief    : Walks a run of WBUF weight blocks two per cycle, tags returns.
// Revision : 1.0
// ============================================================================
module wbuf_tile_scheduler #(
    parameter int N_BANK = 6,
    parameter int DEPTH  = 11,
    parameter int ADDR_W = 4,
    parameter int BANK_W = 3,
    parameter int CNT_W  = 7,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_axis_TVALID,
    output logic              s_axis_TREADY,
    input  logic [BANK_W-1:0] cfg_bank,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [CNT_W-1:0]  cfg_num,
    output logic              wb_a_en,
    output logic              wb_b_en,
    output logic [BANK_W-1:0] wb_a_bank,
    output logic [BANK_W-1:0] wb_b_bank,
    output logic [ADDR_W-1:0] wb_a_addr,
    output logic [ADDR_W-1:0] wb_b_addr,
    output logic              xt_en,
    output logic [ADDR_W-1:0] xt_addr,
    input  logic              mac_ready,
    output logic              mac_valid,
    output logic [1:0]        mac_pair,
    output logic              mac_last,
    output logic              m_axis_TVALID,
    input  logic              m_axis_TREADY,
    output logic              busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [BANK_W:0]   c_NBANK    = N_BANK[BANK_W:0];
    localparam logic [ADDR_W:0]   c_DEPTH    = DEPTH[ADDR_W:0];
    localparam logic [BANK_W:0]   c_BANK_INC = (BANK_W+1)'(1);
    localparam logic [ADDR_W:0]   c_ADDR_INC = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_XT_INC   = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  c_CNT_TWO  = CNT_W'(2);

    // Next block id without a divider: carry the bank into the line, wrap at the end of the buffer.
    function automatic logic [BANK_W+ADDR_W-1:0] ptr_inc(
        input logic [BANK_W-1:0] bank,
        input logic [ADDR_W-1:0] addr
    );
        logic [BANK_W:0] nb;
        logic [ADDR_W:0] na;
        nb = {1'b0, bank} + c_BANK_INC;
        na = {1'b0, addr};
        if (nb == c_NBANK) begin
            nb = '0;
            na = na + c_ADDR_INC;
        end
        if (na == c_DEPTH) begin
            nb = '0;
            na = '0;
        end
        return {nb[BANK_W-1:0], na[ADDR_W-1:0]};
    endfunction

    logic [1:0]        state_q, state_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [ADDR_W-1:0] xt_q, xt_d;
    logic [BANK_W-1:0] a_bank_q, b_bank_q;
    logic [ADDR_W-1:0] a_addr_q, b_addr_q, xt_hold_q;
    logic [2:0]        pipe_q [RD_LAT];

    logic              w_accept;
    logic              w_issue;
    logic              w_two;
    logic              w_last;
    logic              w_start_ok;
    logic              w_pipe_pend;
    logic [BANK_W-1:0] w_b_bank, w_n2_bank;
    logic [ADDR_W-1:0] w_b_addr, w_n2_addr;

    always_comb begin
        w_accept   = (state_q == S_IDLE) && s_axis_TVALID;
        w_issue    = (state_q == S_ISSUE) && mac_ready;
        w_two      = (rem_q >= c_CNT_TWO);
        w_last     = w_issue && !(rem_q > c_CNT_TWO);
        w_start_ok = ({1'b0, cfg_bank} < c_NBANK) && ({1'b0, cfg_addr} < c_DEPTH);
        {w_b_bank, w_b_addr}   = ptr_inc(bank_q, addr_q);
        {w_n2_bank, w_n2_addr} = ptr_inc(w_b_bank, w_b_addr);
    end

    // Only the stages ahead of the output matter: the output stage drains on the DONE transition edge.
    always_comb begin
        w_pipe_pend = 1'b0;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            w_pipe_pend = w_pipe_pend | pipe_q[i][2];
        end
    end

    always_comb begin
        bank_d = bank_q;
        addr_d = addr_q;
        rem_d  = rem_q;
        xt_d   = xt_q;
        if (w_accept) begin
            bank_d = w_start_ok ? cfg_bank : '0;
            addr_d = w_start_ok ? cfg_addr : '0;
            rem_d  = cfg_num;
            xt_d   = '0;
        end else if (w_issue) begin
            bank_d = w_two ? w_n2_bank : w_b_bank;
            addr_d = w_two ? w_n2_addr : w_b_addr;
            rem_d  = rem_q - (w_two ? c_CNT_TWO : c_CNT_ONE);
            xt_d   = xt_q + c_XT_INC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q    <= '0;
            addr_q    <= '0;
            rem_q     <= '0;
            xt_q      <= '0;
            a_bank_q  <= '0;
            a_addr_q  <= '0;
            b_bank_q  <= '0;
            b_addr_q  <= '0;
            xt_hold_q <= '0;
        end else begin
            bank_q <= bank_d;
            addr_q <= addr_d;
            rem_q  <= rem_d;
            xt_q   <= xt_d;
            if (w_issue) begin
                a_bank_q  <= bank_q;
                a_addr_q  <= addr_q;
                xt_hold_q <= xt_q;
                if (w_two) begin
                    b_bank_q <= w_b_bank;
                    b_addr_q <= w_b_addr;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= {w_issue, w_issue && w_two, w_last};
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (s_axis_TVALID) begin
                    state_d = (cfg_num == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!w_pipe_pend) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (m_axis_TREADY) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        s_axis_TREADY = (state_q == S_IDLE);
        m_axis_TVALID = (state_q == S_DONE);
        busy          = (state_q != S_IDLE);
        wb_a_en       = w_issue;
        wb_b_en       = w_issue && w_two;
        xt_en         = w_issue;
        wb_a_bank     = w_issue ? bank_q : a_bank_q;
        wb_a_addr     = w_issue ? addr_q : a_addr_q;
        wb_b_bank     = (w_issue && w_two) ? w_b_bank : b_bank_q;
        wb_b_addr     = (w_issue && w_two) ? w_b_addr : b_addr_q;
        xt_addr       = w_issue ? xt_q : xt_hold_q;
        mac_valid     = pipe_q[RD_LAT-1][2];
        mac_pair      = {pipe_q[RD_LAT-1][1], pipe_q[RD_LAT-1][2]};
        mac_last      = pipe_q[RD_LAT-1][0];
    end

endmodule
`default_nettype wire

// File: tb/tb_wbuf_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_wbuf_tile_scheduler
// Brief    : Directed self-checking bench for wbuf_tile_scheduler.
// Revision : 1.0
// ============================================================================
module tb_wbuf_tile_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_axis_TVALID;
    logic       s_axis_TREADY;
    logic [2:0] cfg_bank;
    logic [3:0] cfg_addr;
    logic [6:0] cfg_num;
    logic       wb_a_en, wb_b_en;
    logic [2:0] wb_a_bank, wb_b_bank;
    logic [3:0] wb_a_addr, wb_b_addr;
    logic       xt_en;
    logic [3:0] xt_addr;
    logic       mac_ready;
    logic       mac_valid;
    logic [1:0] mac_pair;
    logic       mac_last;
    logic       m_axis_TVALID;
    logic       m_axis_TREADY;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int mv_cnt = 0;
    int last_cnt = 0;
    int oor_cnt = 0;
    int iss_cnt = 0;
    logic [1:0] last_pair = 2'b00;

    wbuf_tile_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_TVALID (s_axis_TVALID),
        .s_axis_TREADY (s_axis_TREADY),
        .cfg_bank      (cfg_bank),
        .cfg_addr      (cfg_addr),
        .cfg_num       (cfg_num),
        .wb_a_en       (wb_a_en),
        .wb_b_en       (wb_b_en),
        .wb_a_bank     (wb_a_bank),
        .wb_b_bank     (wb_b_bank),
        .wb_a_addr     (wb_a_addr),
        .wb_b_addr     (wb_b_addr),
        .xt_en         (xt_en),
        .xt_addr       (xt_addr),
        .mac_ready     (mac_ready),
        .mac_valid     (mac_valid),
        .mac_pair      (mac_pair),
        .mac_last      (mac_last),
        .m_axis_TVALID (m_axis_TVALID),
        .m_axis_TREADY (m_axis_TREADY),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mac_valid) mv_cnt <= mv_cnt + 1;
        if (wb_a_en) iss_cnt <= iss_cnt + 1;
        if (mac_last) begin
            last_cnt  <= last_cnt + 1;
            last_pair <= mac_pair;
        end
        if ((wb_a_en && (wb_a_bank >= 3'd6 || wb_a_addr >= 4'd11)) ||
            (wb_b_en && (wb_b_bank >= 3'd6 || wb_b_addr >= 4'd11)))
            oor_cnt <= oor_cnt + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Block-id model: blk -> (blk % 6, blk / 6) over a 66-block space.
    task automatic run_tile(input int b, input int a, input int n, input logic [15:0] pat,
                            input int plen, input int exp_lat, input bit early_ack);
        int t0, blk, rem, xt, iss, k, w, mv0, lc0;
        logic [1:0] exp_pair;
        mv0 = mv_cnt;
        lc0 = last_cnt;
        exp_pair = 2'b00;
        m_axis_TREADY = early_ack;
        s_axis_TVALID = 1'b1;
        cfg_bank = 3'(b);
        cfg_addr = 4'(a);
        cfg_num  = 7'(n);
        settle();
        chk("cmd_tready", int'(s_axis_TREADY), 1);
        t0 = cyc;
        tick();
        s_axis_TVALID = 1'b0;
        blk = (b >= 6 || a >= 11) ? 0 : a * 6 + b;
        rem = n;
        xt = 0;
        iss = 0;
        k = 0;
        while (rem > 0 && k < 200) begin
            mac_ready = (k < plen) ? pat[k] : 1'b1;
            settle();
            chk("busy", int'(busy), 1);
            if (mac_ready) begin
                chk("a_en", int'(wb_a_en), 1);
                chk("a_bank", int'(wb_a_bank), blk % 6);
                chk("a_addr", int'(wb_a_addr), blk / 6);
                if (rem >= 2) begin
                    chk("b_en", int'(wb_b_en), 1);
                    chk("b_bank", int'(wb_b_bank), ((blk + 1) % 66) % 6);
                    chk("b_addr", int'(wb_b_addr), ((blk + 1) % 66) / 6);
                end else begin
                    chk("b_en_single", int'(wb_b_en), 0);
                end
                chk("xt_en", int'(xt_en), 1);
                chk("xt_addr", int'(xt_addr), xt);
                exp_pair = (rem >= 2) ? 2'b11 : 2'b01;
                blk = (blk + ((rem >= 2) ? 2 : 1)) % 66;
                rem = rem - ((rem >= 2) ? 2 : 1);
                xt = (xt + 1) % 16;
                iss++;
            end else begin
                chk("stall_en", int'({wb_a_en, wb_b_en, xt_en}), 0);
            end
            tick();
            k++;
        end
        mac_ready = 1'b1;
        settle();
        chk("post_issue_en", int'(wb_a_en), 0);
        w = 0;
        while (!m_axis_TVALID && w < 50) begin
            tick();
            settle();
            w++;
        end
        chk("done_valid", int'(m_axis_TVALID), 1);
        chk("done_lat", cyc - t0, exp_lat);
        chk("done_tready", int'(s_axis_TREADY), 0);
        if (!early_ack) m_axis_TREADY = 1'b1;
        tick();
        m_axis_TREADY = 1'b0;
        settle();
        chk("done_clear", int'(m_axis_TVALID), 0);
        chk("idle_busy", int'(busy), 0);
        chk("mac_valid_cnt", mv_cnt - mv0, iss);
        chk("mac_last_cnt", last_cnt - lc0, 1);
        chk("mac_last_pair", int'(last_pair), int'(exp_pair));
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, is0;
        rst = 1'b1;
        s_axis_TVALID = 1'b0;
        cfg_bank = '0;
        cfg_addr = '0;
        cfg_num = '0;
        mac_ready = 1'b0;
        m_axis_TREADY = 1'b0;
        #3;
        chk("rst_tready", int'(s_axis_TREADY), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_enables", int'({wb_a_en, wb_b_en, xt_en}), 0);
        chk("rst_mac", int'({mac_valid, mac_pair, mac_last}), 0);
        chk("rst_done", int'(m_axis_TVALID), 0);
        chk("rst_addrs", int'({wb_a_bank, wb_a_addr, wb_b_bank, wb_b_addr, xt_addr}), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Full buffer: 33 double issues, done at T+36.
        run_tile(0, 0, 66, 16'h0000, 0, 36, 1'b0);
        // Odd count from the last bank: final single issue on port A.
        run_tile(5, 0, 5, 16'h0000, 0, 6, 1'b0);
        // Wrap at the end of the buffer, with done acknowledged on entry.
        run_tile(4, 10, 3, 16'h0000, 0, 5, 1'b1);
        // Backpressure 1,0,0,1,1,0,1.
        run_tile(0, 0, 8, 16'h0059, 7, 10, 1'b0);
        // Out-of-range start collapses to (0,0).
        run_tile(7, 3, 2, 16'h0000, 0, 4, 1'b0);

        // Zero count: done held five cycles, cleared after acknowledge.
        is0 = iss_cnt;
        s_axis_TVALID = 1'b1;
        cfg_bank = 3'd2;
        cfg_addr = 4'd1;
        cfg_num = 7'd0;
        settle();
        t0 = cyc;
        tick();
        s_axis_TVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("zero_done_hold", int'(m_axis_TVALID), 1);
            chk("zero_tready", int'(s_axis_TREADY), 0);
            tick();
        end
        m_axis_TREADY = 1'b1;
        settle();
        chk("zero_done_ack", int'(m_axis_TVALID), 1);
        chk("zero_lat", cyc - t0, 6);
        tick();
        m_axis_TREADY = 1'b0;
        settle();
        chk("zero_done_clear", int'(m_axis_TVALID), 0);
        chk("zero_idle_tready", int'(s_axis_TREADY), 1);
        chk("zero_no_issue", iss_cnt - is0, 0);
        tick();

        // Reset in the third issue cycle of a 20-block tile.
        mac_ready = 1'b1;
        s_axis_TVALID = 1'b1;
        cfg_bank = 3'd0;
        cfg_addr = 4'd0;
        cfg_num = 7'd20;
        settle();
        tick();
        s_axis_TVALID = 1'b0;
        tick();
        tick();
        settle();
        chk("mid_a_en", int'(wb_a_en), 1);
        chk("mid_mac_valid", int'(mac_valid), 1);
        chk("mid_xt_addr", int'(xt_addr), 2);
        rst = 1'b1;
        #1;
        chk("arst_enables", int'({wb_a_en, wb_b_en, xt_en}), 0);
        chk("arst_mac", int'({mac_valid, mac_pair, mac_last}), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(m_axis_TVALID), 0);
        chk("arst_tready", int'(s_axis_TREADY), 1);
        chk("arst_addrs", int'({wb_a_bank, wb_a_addr, wb_b_bank, wb_b_addr, xt_addr}), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        run_tile(2, 3, 4, 16'h0000, 0, 5, 1'b0);

        chk("no_out_of_range", oor_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wbuf_tile_scheduler.md
# wbuf_tile_scheduler

Sequencer for the 6-bank dual-port weight buffer (WBUF) and the XT vector ROM feeding the MAC/reduction tile datapath. It accepts one tile command per AXIS-style handshake and walks a contiguous run of weight blocks, where block id = bank + N_BANK·addr. It issues up to two block reads per cycle, one on each WBUF port, plus one XT read per issue cycle. It tags the returning data for the MAC array and signals tile completion with a held done handshake.

## Interface
- N_BANK, 6, number of WBUF banks
- DEPTH, 11, lines per bank; the block space is N_BANK·DEPTH ids
- ADDR_W, 4, WBUF line and XT address width
- BANK_W, 3, bank index width (≥ clog2(N_BANK))
- CNT_W, 7, block-count width (≥ clog2(N_BANK·DEPTH+1))
- RD_LAT, 2, WBUF/XT read latency in cycles (≥1)

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, asynchronous, active-high
- s_axis_TVALID  in  1  tile command valid
- s_axis_TREADY  out  1  command accepted when high together with TVALID
- cfg_bank  in  BANK_W  start bank; sampled at the command handshake
- cfg_addr  in  ADDR_W  start line; sampled at the command handshake
- cfg_num  in  CNT_W  number of blocks; sampled at the command handshake
- wb_a_en, wb_b_en  out  1  read enables for WBUF port A and port B
- wb_a_bank, wb_b_bank  out  BANK_W  bank select per port
- wb_a_addr, wb_b_addr  out  ADDR_W  line address per port
- xt_en  out  1  XT ROM read enable
- xt_addr  out  ADDR_W  XT ROM address
- mac_ready  in  1  issue credit: the MAC array can absorb data RD_LAT cycles later
- mac_valid  out  1  WBUF/XT data valid this cycle
- mac_pair  out  2  bit0 = port A data valid, bit1 = port B data valid
- mac_last  out  1  final data beat of the tile
- m_axis_TVALID  out  1  tile done
- m_axis_TREADY  in  1  done acknowledge
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- **IDLE**
  - s_axis_TREADY=1.
  - On handshake, latch (cfg_bank, cfg_addr) as the current pointer, set rem=cfg_num and xt_addr=0.
  - If cfg_num=0, go to DONE; otherwise go to ISSUE.
  - A start pointer out of range (cfg_bank≥N_BANK or cfg_addr≥DEPTH) is reduced to (0,0).
- **ISSUE**
  - A cycle with mac_ready=1 is an issue cycle:
    - wb_a_en=1 at the current pointer.
    - If rem≥2, wb_b_en=1 at pointer+1.
    - xt_en=1.
    - Pointer advances by 2 (or by 1 when only port A issued); rem decrements by the same amount; xt_addr increments and wraps modulo 2^ADDR_W.
  - A cycle with mac_ready=0 issues nothing and holds all state.
  - Transition to DRAIN in the cycle after rem reaches 0.
- **Pointer increment (no divider):**
  - bank+1; if the result is N_BANK, set bank=0 and addr+1.
  - If addr reaches DEPTH, wrap to (0,0).
  - Port B's pointer is computed the same way from port A's pointer.
- **DRAIN**: wait until the RD_LAT-deep valid shift register is empty, then go to DONE.
- **DONE**: m_axis_TVALID=1, held until m_axis_TREADY=1, then go to IDLE. s_axis_TREADY=0 in DONE.
- **Return path:**
  - A shift register of {a_en, b_en, last}, RD_LAT deep, shifts every cycle regardless of mac_ready.
  - mac_valid = a_en of the delayed entry; mac_pair = delayed {b_en, a_en}; mac_last = delayed last.
  - last is set on the final issue cycle.
- All enables are low outside issue cycles.
- Bank and address outputs are held at their last value when not enabled; their value is don't-care.

## Timing
- **Reset:** all outputs are 0 and the FSM is in IDLE, except s_axis_TREADY, which is 1 in IDLE. Reset takes effect immediately and asynchronously, including mid-tile: any in-flight valids are discarded and no done is issued.
- **Command to first read:** handshake at cycle T; first issue at T+1 if mac_ready=1.
- **Read to data:** issue at cycle t gives mac_valid at t+RD_LAT.
- **Full-rate tile, N blocks:**
  - ceil(N/2) issue cycles.
  - DRAIN lasts RD_LAT cycles after the last issue.
  - m_axis_TVALID rises at T+1+ceil(N/2)+RD_LAT.
- **Back-to-back commands:** minimum gap is one cycle (DONE→IDLE); a new command is never accepted while busy.
- **Simultaneous events:** m_axis_TREADY high on DONE entry gives a one-cycle done pulse.

## Test plan
- **Full buffer:** (0,0), num=66, mac_ready=1 → 33 issue cycles; the first issue is A=(0,0), B=(1,0); the last is A=(4,10), B=(5,10) with mac_last; xt_addr sequence 0..15,0..15,0; m_axis_TVALID rises at T+36 with RD_LAT=2.
- **Odd count:** (5,0), num=5 → issues (5,0)&(0,1), (1,1)&(2,1), then (3,1) alone; the final mac_pair=01 with mac_last=1.
- **Wrap:** (4,10), num=3 → (4,10)&(5,10), then (0,0); no out-of-range address is ever driven.
- **Backpressure:** num=8, mac_ready toggles 1,0,0,1,1,0,1 → exactly 4 issue cycles with pointers identical to the unstalled run; mac_valid count=4; no enables during stalled cycles.
- **Zero count and done hold:** num=0 → no enables; m_axis_TVALID at T+1, held for 5 cycles with TREADY=0, then cleared the cycle after TREADY=1; s_axis_TREADY=0 throughout DONE.
- **Reset mid-tile:** rst asserted during the 3rd issue cycle of num=20 → all outputs 0 asynchronously; a new command after release starts cleanly with xt_addr=0.
